// File: rtl/half_adder_pkg.sv
// Shared definitions for the half-adder lane array: width limit and per-lane result type.
package half_adder_pkg;

    // Widest lane count the core accepts.
    localparam int unsigned WIDTH_MAX = 64;

    // Result of one half-adder lane.
    typedef struct packed {
        logic sum;
        logic carry;
    } lane_result_t;

endpackage

// File: rtl/half_adder_cell.sv
// One-bit combinational half adder: sum is the XOR, carry is the AND of the two addends.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/half_adder_core.sv
// Array of WIDTH independent half-adder lanes with an optional output register stage
// and an OR-reduction of all lane carries.
module half_adder_core
    import half_adder_pkg::*;
#(
    parameter int unsigned WIDTH      = 1,
    parameter bit          REGISTERED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum_out,
    output logic [WIDTH-1:0] carry_out,
    output logic             out_valid,
    output logic             carry_any
);

    // Reject illegal lane counts before anything gets built.
    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_check
        $fatal(1, "half_adder_core: WIDTH=%0d outside legal range 1..%0d", WIDTH, WIDTH_MAX);
    end

    lane_result_t     lane_res [WIDTH];
    logic [WIDTH-1:0] lane_sum;
    logic [WIDTH-1:0] lane_carry;

    // One cell per lane; lanes never exchange carries.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a     (a_in[i]),
            .b     (b_in[i]),
            .sum   (lane_res[i].sum),
            .carry (lane_res[i].carry)
        );
        assign lane_sum[i]   = lane_res[i].sum;
        assign lane_carry[i] = lane_res[i].carry;
    end

    if (REGISTERED) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic [WIDTH-1:0] carry_q;
        logic             valid_q;

        // Capture lane results only on valid input so idle-cycle garbage never reaches the outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                carry_q <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= in_valid;
                if (in_valid) begin
                    sum_q   <= lane_sum;
                    carry_q <= lane_carry;
                end
            end
        end

        assign sum_out   = sum_q;
        assign carry_out = carry_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        assign sum_out   = lane_sum;
        assign carry_out = lane_carry;
        assign out_valid = in_valid;
    end

    // Taken from the output value so it tracks the register stage with no added delay.
    assign carry_any = |carry_out;

endmodule

// File: tb/tb_half_adder_core.sv
// Self-checking bench: three instances (1-lane registered, 1-lane combinational,
// 4-lane registered) driven from shared stimulus and compared to an arithmetic model.
module tb_half_adder_core;

    logic       clk;
    logic       rst_n;
    logic [3:0] a_drv;
    logic [3:0] b_drv;
    logic       vld;

    logic       r1_sum, r1_carry, r1_valid, r1_any;
    logic       c1_sum, c1_carry, c1_valid, c1_any;
    logic [3:0] r4_sum, r4_carry;
    logic       r4_valid, r4_any;

    int n_cmp;
    int n_err;

    // Model state for the registered outputs.
    logic [3:0] exp_sum;
    logic [3:0] exp_carry;
    logic       exp_valid;

    half_adder_core #(.WIDTH(1), .REGISTERED(1'b1)) u_r1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_in      (a_drv[0]),
        .b_in      (b_drv[0]),
        .in_valid  (vld),
        .sum_out   (r1_sum),
        .carry_out (r1_carry),
        .out_valid (r1_valid),
        .carry_any (r1_any)
    );

    half_adder_core #(.WIDTH(1), .REGISTERED(1'b0)) u_c1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_in      (a_drv[0]),
        .b_in      (b_drv[0]),
        .in_valid  (vld),
        .sum_out   (c1_sum),
        .carry_out (c1_carry),
        .out_valid (c1_valid),
        .carry_any (c1_any)
    );

    half_adder_core #(.WIDTH(4), .REGISTERED(1'b1)) u_r4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_in      (a_drv),
        .b_in      (b_drv),
        .in_valid  (vld),
        .sum_out   (r4_sum),
        .carry_out (r4_carry),
        .out_valid (r4_valid),
        .carry_any (r4_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane result by counting ones: {carry, sum} = binary value of a + b.
    function automatic logic [1:0] lane_add(input logic a, input logic b);
        int s;
        s = int'(a) + int'(b);
        return {(s >= 2), (s % 2 == 1)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, " r1_sum"},   64'(r1_sum),   64'(exp_sum[0]));
        chk({tag, " r1_carry"}, 64'(r1_carry), 64'(exp_carry[0]));
        chk({tag, " r1_valid"}, 64'(r1_valid), 64'(exp_valid));
        chk({tag, " r1_any"},   64'(r1_any),   64'(exp_carry[0]));
        chk({tag, " r4_sum"},   64'(r4_sum),   64'(exp_sum));
        chk({tag, " r4_carry"}, 64'(r4_carry), 64'(exp_carry));
        chk({tag, " r4_valid"}, 64'(r4_valid), 64'(exp_valid));
        chk({tag, " r4_any"},   64'(r4_any),   64'(exp_carry != 4'd0));
    endtask

    task automatic check_comb(input string tag);
        logic [1:0] r;
        r = lane_add(a_drv[0], b_drv[0]);
        chk({tag, " c1_sum"},   64'(c1_sum),   64'(r[0]));
        chk({tag, " c1_carry"}, 64'(c1_carry), 64'(r[1]));
        chk({tag, " c1_valid"}, 64'(c1_valid), 64'(vld));
        chk({tag, " c1_any"},   64'(c1_any),   64'(r[1]));
    endtask

    // Drive one cycle of input, check the combinational instance, then the registered ones.
    task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic v);
        logic [1:0] r;
        a_drv = a;
        b_drv = b;
        vld   = v;
        #1;
        check_comb(tag);
        @(posedge clk);
        if (rst_n) begin
            exp_valid = v;
            if (v) begin
                for (int i = 0; i < 4; i++) begin
                    r = lane_add(a[i], b[i]);
                    exp_sum[i]   = r[0];
                    exp_carry[i] = r[1];
                end
            end
        end
        #1;
        check_regs(tag);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        exp_sum   = '0;
        exp_carry = '0;
        exp_valid = 1'b0;
        rst_n     = 1'b0;
        a_drv     = 4'hF;
        b_drv     = 4'hF;
        vld       = 1'b1;

        // Reset holds registered outputs at zero even with active inputs and clock edges.
        #12;
        check_regs("reset");
        check_comb("reset_comb");
        rst_n = 1'b1;

        // Full truth table on lane 0, back-to-back.
        step("tt00", 4'b0000, 4'b0000, 1'b1);
        step("tt01", 4'b0000, 4'b0001, 1'b1);
        step("tt10", 4'b0001, 4'b0000, 1'b1);
        step("tt11", 4'b0001, 4'b0001, 1'b1);

        // Multi-lane vectors.
        step("w4a", 4'b1100, 4'b1010, 1'b1);
        step("w4b", 4'b0101, 4'b0010, 1'b1);

        // Valid pattern 1,0,1: results held during the idle cycle.
        step("pat1", 4'b1011, 4'b0111, 1'b1);
        step("pat0", 4'($urandom), 4'($urandom), 1'b0);
        step("pat2", 4'b0000, 4'b1001, 1'b1);

        // Reset between edges with a result in flight.
        step("pre_rst", 4'b1111, 4'b1111, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_sum   = '0;
        exp_carry = '0;
        exp_valid = 1'b0;
        check_regs("async_rst");
        vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_idle", 4'($urandom), 4'($urandom), 1'b0);
        step("post_rst_first", 4'b0110, 4'b0011, 1'b1);

        // Randomized traffic, including idle cycles with random data.
        for (int k = 0; k < 40; k++) begin
            step("rand", 4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/half_adder_core.md
HALF_ADDER_CORE -- requirements
Module: half_adder_core

Interface
REQ-001 Parameter: WIDTH, default 1, number of independent bit-lanes; legal range 1..64.
REQ-002 Parameter: REGISTERED, default 1; 1 = outputs registered (latency 1 cycle), 0 = outputs combinational (latency 0).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: a_in  input  WIDTH  addend A, one bit per lane.
REQ-007 Port: b_in  input  WIDTH  addend B, one bit per lane.
REQ-008 Port: in_valid  input  1  qualifies a_in/b_in for the current cycle.
REQ-009 Port: sum_out  output  WIDTH  per-lane sum bit.
REQ-010 Port: carry_out  output  WIDTH  per-lane carry bit.
REQ-011 Port: out_valid  output  1  qualifies sum_out/carry_out.
REQ-012 Port: carry_any  output  1  OR of all carry_out lanes.

Function
REQ-013 Each lane i SHALL compute sum_out[i] = a_in[i] XOR b_in[i] and carry_out[i] = a_in[i] AND b_in[i]; there is no carry propagation between lanes.
REQ-014 Truth table per lane (a,b -> sum,carry): 00->00, 01->10, 10->10, 11->01.
REQ-015 With REGISTERED=1, sum_out, carry_out and out_valid SHALL update on the rising clk edge after the cycle in which in_valid=1, so latency is exactly 1 cycle.
REQ-016 With REGISTERED=1 and in_valid=0 at a clock edge, out_valid SHALL go to 0, and sum_out/carry_out SHALL hold their previous values.
REQ-017 With REGISTERED=0, sum_out/carry_out SHALL follow a_in/b_in combinationally and out_valid SHALL equal in_valid; clk is unused and rst_n has no effect on the outputs in this mode.
REQ-018 carry_any SHALL be derived combinationally from the carry_out port value, with no extra latency.
REQ-019 Back-to-back valid inputs SHALL be accepted every cycle, giving a throughput of 1 per clock; there is no backpressure.
REQ-020 X on a_in/b_in while in_valid=0 SHALL NOT propagate to the registered outputs.

Reset
REQ-021 While rst_n=0 (REGISTERED=1): sum_out=0, carry_out=0, out_valid=0, carry_any=0, applied asynchronously without waiting for a clock edge.
REQ-022 Reset asserted mid-stream SHALL discard the in-flight result.
REQ-023 After rst_n deasserts, the first valid output SHALL appear 1 cycle after the first in_valid=1 sampled with rst_n=1.

Structure
REQ-024 A shared package half_adder_pkg SHALL hold WIDTH_MAX=64 and the per-lane result struct {sum, carry}.
REQ-025 A single leaf sub-module half_adder_cell (1-bit, combinational, ports a, b, sum, carry) SHALL be instantiated WIDTH times by a generate loop.
REQ-026 The top level SHALL contain only the lane generate loop, the optional output register stage, and the carry_any reduction.
REQ-027 Parameter legality (WIDTH in range) SHALL be checked at elaboration, and an illegal value SHALL stop elaboration.

Verification
REQ-028 WIDTH=1, REGISTERED=1, after reset: apply (a,b) = 00, 01, 10, 11 with in_valid=1, 10 ns apart -> one cycle later, (sum,carry) = 00, 10, 10, 01 and out_valid=1 for each.
REQ-029 WIDTH=1, REGISTERED=0: sweep all 4 input combinations -> outputs match REQ-014 in the same time step, and out_valid = in_valid.
REQ-030 WIDTH=4, REGISTERED=1: a=4'b1100, b=4'b1010 -> sum_out=4'b0110, carry_out=4'b1000, carry_any=1; then a=4'b0101, b=4'b0010 -> sum_out=4'b0111, carry_out=0, carry_any=0.
REQ-031 Drive a=1, b=1, in_valid=1, then assert rst_n=0 between clock edges -> all outputs go to 0 immediately; after release with in_valid=0, out_valid stays 0.
REQ-032 in_valid pattern 1,0,1 with inputs 11, 00, 01 -> out_valid pattern 1,0,1; sum/carry = 01, then held at 01, then 10.
